morse_entry_buffer: RTL

Parametrised successor to the fixed 20-bit player-2 morse accumulator. It takes decoded dot/dash pulses from the existing morse input decoder and packs them into a shift register: dot = 2'b10, dash = 4'b1110. It also tracks symbol count and bit length, supports undo of the last symbol, and flags overflow instead of silently truncating. On submit it runs a registered compare against a target code through a small FSM, producing correct/wrong results.

---
 rtl/morse_pkg.sv | 17 +
 rtl/morse_entry_buffer_if.sv | 36 +++
 rtl/morse_symbol_stack.sv | 55 +++++
 rtl/morse_entry_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared constants and state type for the morse entry buffer.
// Symbol encodings are right-aligned bit patterns appended to the packed entry.
package morse_pkg;

  localparam logic [1:0] DOT_CODE  = 2'b10;
  localparam int         DOT_LEN   = 2;
  localparam logic [3:0] LINE_CODE = 4'b1110;
  localparam int         LINE_LEN  = 4;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    CHECK  = 2'd1,
    RESULT = 2'd2,
    LOCKED = 2'd3
  } morse_state_e;

endpackage

// File: rtl/morse_entry_buffer_if.sv
// morse_entry_buffer_if: command pulses, target code and entry status of the
// morse entry buffer.
//   master: drives ld_dot, ld_line, undo, done_input, clear, target;
//           observes q, sym_count, bit_len, overflow, correct, wrong, locked.
//   slave : the buffer itself (directions reversed).
interface morse_entry_buffer_if #(
  parameter int MAX_SYMBOLS = 5
);
  localparam int VALUE_W = 4 * MAX_SYMBOLS;
  localparam int CNT_W   = $clog2(MAX_SYMBOLS + 1);
  localparam int BL_W    = $clog2(VALUE_W + 1);

  logic               ld_dot;
  logic               ld_line;
  logic               undo;
  logic               done_input;
  logic               clear;
  logic [VALUE_W-1:0] target;
  logic [VALUE_W-1:0] q;
  logic [CNT_W-1:0]   sym_count;
  logic [BL_W-1:0]    bit_len;
  logic               overflow;
  logic               correct;
  logic               wrong;
  logic               locked;

  modport master (
    output ld_dot, ld_line, undo, done_input, clear, target,
    input  q, sym_count, bit_len, overflow, correct, wrong, locked
  );

  modport slave (
    input  ld_dot, ld_line, undo, done_input, clear, target,
    output q, sym_count, bit_len, overflow, correct, wrong, locked
  );
endinterface

// File: rtl/morse_symbol_stack.sv
// morse_symbol_stack: records the kind of each held symbol (1 = dash, 0 = dot)
// so undo knows how many bits to drop.  Bit 0 is the most recent symbol.
//   clock, resetn : clock, synchronous active-low reset
//   clear         : empty the stack
//   push/push_val : append a symbol (caller guarantees not full)
//   pop           : drop the most recent symbol (caller guarantees not empty)
//   top           : kind of the most recent symbol
//   empty, full   : occupancy flags; sym_count: symbols held
module morse_symbol_stack #(
  parameter int MAX_SYMBOLS = 5,
  parameter int CNT_W       = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             push,
  input  logic             push_val,
  input  logic             pop,
  output logic             top,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] sym_count
);

  logic [MAX_SYMBOLS-1:0] hist_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [MAX_SYMBOLS:0]   pushed_s;

  assign pushed_s  = {hist_r, push_val};
  assign top       = hist_r[0];
  assign empty     = (cnt_r == {CNT_W{1'b0}});
  assign full      = (cnt_r == CNT_W'(MAX_SYMBOLS));
  assign sym_count = cnt_r;

  // History shift register and symbol counter.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hist_r <= {MAX_SYMBOLS{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else if (clear) begin
      hist_r <= {MAX_SYMBOLS{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else if (push) begin
      hist_r <= pushed_s[MAX_SYMBOLS-1:0];
      cnt_r  <= cnt_r + CNT_W'(1);
    end else if (pop) begin
      hist_r <= hist_r >> 1;
      cnt_r  <= cnt_r - CNT_W'(1);
    end else begin
      hist_r <= hist_r;
      cnt_r  <= cnt_r;
    end
  end

endmodule

// File: rtl/morse_entry_buffer.sv
// morse_entry_buffer: packs dot/dash pulses into a right-aligned shift
// register (dot = 10, dash = 1110), supports undo, flags overflow, and on
// submit compares the entry with a target through ENTRY/CHECK/RESULT states.
//   clock, resetn : clock, synchronous active-low reset
//   bus (slave)   : ld_dot, ld_line, undo, done_input, clear, target in;
//                   q, sym_count, bit_len, overflow, correct, wrong, locked out
// Optional feature macro MORSE_LOCKOUT_EN: after MAX_TRIES wrong results the
// buffer enters LOCKED, leaving it only on resetn.  Without it locked is 0.
module morse_entry_buffer
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 5,
  parameter int MAX_TRIES   = 3
) (
  input  logic                 clock,
  input  logic                 resetn,
  morse_entry_buffer_if.slave  bus
);

  localparam int VALUE_W = 4 * MAX_SYMBOLS;
  localparam int CNT_W   = $clog2(MAX_SYMBOLS + 1);
  localparam int BL_W    = $clog2(VALUE_W + 1);
  localparam logic [BL_W:0] VALUE_W_EXT = (BL_W + 1)'(VALUE_W);

  morse_state_e       state_r, state_nxt_s;
  logic [VALUE_W-1:0] q_r, q_nxt_s;
  logic [BL_W-1:0]    bit_len_r, bit_len_nxt_s;
  logic               overflow_r, overflow_nxt_s;
  logic               correct_r, correct_nxt_s;
  logic               wrong_r, wrong_nxt_s;
  logic               push_s, push_val_s, pop_s, stk_clear_s;
  logic               top_s, empty_s, full_s;
  logic [CNT_W-1:0]   sym_count_s;
  logic [BL_W:0]      len_dot_s, len_line_s;
  logic               match_s;

  morse_symbol_stack #(
    .MAX_SYMBOLS(MAX_SYMBOLS),
    .CNT_W      (CNT_W)
  ) u_stack (
    .clock    (clock),
    .resetn   (resetn),
    .clear    (stk_clear_s),
    .push     (push_s),
    .push_val (push_val_s),
    .pop      (pop_s),
    .top      (top_s),
    .empty    (empty_s),
    .full     (full_s),
    .sym_count(sym_count_s)
  );

  // One bit wider than bit_len so the fit test cannot wrap.
  assign len_dot_s  = {1'b0, bit_len_r} + (BL_W + 1)'(DOT_LEN);
  assign len_line_s = {1'b0, bit_len_r} + (BL_W + 1)'(LINE_LEN);
  assign match_s    = (q_r == bus.target);

`ifdef MORSE_LOCKOUT_EN
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  logic [TRIES_W-1:0] tries_r, tries_nxt_s;
  logic               locked_r;

  // Wrong-result counter and lockout flag.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      tries_r  <= {TRIES_W{1'b0}};
      locked_r <= 1'b0;
    end else begin
      tries_r  <= tries_nxt_s;
      locked_r <= (state_nxt_s == LOCKED);
    end
  end

  assign bus.locked = locked_r;
`else
  assign bus.locked = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r    <= ENTRY;
      q_r        <= {VALUE_W{1'b0}};
      bit_len_r  <= {BL_W{1'b0}};
      overflow_r <= 1'b0;
      correct_r  <= 1'b0;
      wrong_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      q_r        <= q_nxt_s;
      bit_len_r  <= bit_len_nxt_s;
      overflow_r <= overflow_nxt_s;
      correct_r  <= correct_nxt_s;
      wrong_r    <= wrong_nxt_s;
    end
  end

  // Next-state, packing and compare logic; one action per cycle by priority.
  always_comb begin
    state_nxt_s    = state_r;
    q_nxt_s        = q_r;
    bit_len_nxt_s  = bit_len_r;
    overflow_nxt_s = overflow_r;
    correct_nxt_s  = correct_r;
    wrong_nxt_s    = wrong_r;
    push_s         = 1'b0;
    push_val_s     = 1'b0;
    pop_s          = 1'b0;
    stk_clear_s    = 1'b0;
`ifdef MORSE_LOCKOUT_EN
    tries_nxt_s    = tries_r;
`endif
    case (state_r)
      ENTRY: begin
        if (bus.clear) begin
          q_nxt_s        = {VALUE_W{1'b0}};
          bit_len_nxt_s  = {BL_W{1'b0}};
          overflow_nxt_s = 1'b0;
          correct_nxt_s  = 1'b0;
          wrong_nxt_s    = 1'b0;
          stk_clear_s    = 1'b1;
        end else if (bus.ld_line) begin
          if (!full_s && (len_line_s <= VALUE_W_EXT)) begin
            q_nxt_s       = {q_r[VALUE_W-LINE_LEN-1:0], LINE_CODE};
            bit_len_nxt_s = len_line_s[BL_W-1:0];
            push_s        = 1'b1;
            push_val_s    = 1'b1;
          end else begin
            overflow_nxt_s = 1'b1;
          end
        end else if (bus.ld_dot) begin
          if (!full_s && (len_dot_s <= VALUE_W_EXT)) begin
            q_nxt_s       = {q_r[VALUE_W-DOT_LEN-1:0], DOT_CODE};
            bit_len_nxt_s = len_dot_s[BL_W-1:0];
            push_s        = 1'b1;
            push_val_s    = 1'b0;
          end else begin
            overflow_nxt_s = 1'b1;
          end
        end else if (bus.undo) begin
          if (!empty_s) begin
            // History top tells how wide the last symbol was.
            if (top_s) begin
              q_nxt_s       = q_r >> LINE_LEN;
              bit_len_nxt_s = bit_len_r - BL_W'(LINE_LEN);
            end else begin
              q_nxt_s       = q_r >> DOT_LEN;
              bit_len_nxt_s = bit_len_r - BL_W'(DOT_LEN);
            end
            pop_s = 1'b1;
          end else begin
            pop_s = 1'b0;
          end
        end else if (bus.done_input) begin
          state_nxt_s = CHECK;
        end else begin
          state_nxt_s = ENTRY;
        end
      end
      CHECK: begin
        correct_nxt_s = match_s;
        wrong_nxt_s   = !match_s;
        state_nxt_s   = RESULT;
`ifdef MORSE_LOCKOUT_EN
        if (match_s) begin
          tries_nxt_s = {TRIES_W{1'b0}};
        end else begin
          tries_nxt_s = tries_r + TRIES_W'(1);
          if (tries_nxt_s == TRIES_W'(MAX_TRIES)) begin
            state_nxt_s = LOCKED;
          end else begin
            state_nxt_s = RESULT;
          end
        end
`endif
      end
      RESULT: begin
        if (bus.clear) begin
          q_nxt_s        = {VALUE_W{1'b0}};
          bit_len_nxt_s  = {BL_W{1'b0}};
          overflow_nxt_s = 1'b0;
          correct_nxt_s  = 1'b0;
          wrong_nxt_s    = 1'b0;
          stk_clear_s    = 1'b1;
          state_nxt_s    = ENTRY;
        end else begin
          state_nxt_s = RESULT;
        end
      end
`ifdef MORSE_LOCKOUT_EN
      LOCKED: begin
        state_nxt_s = LOCKED;
      end
`endif
      default: begin
        state_nxt_s = ENTRY;
      end
    endcase
  end

  assign bus.q         = q_r;
  assign bus.sym_count = sym_count_s;
  assign bus.bit_len   = bit_len_r;
  assign bus.overflow  = overflow_r;
  assign bus.correct   = correct_r;
  assign bus.wrong     = wrong_r;

endmodule
